// File: rtl/mem_stage_hs_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   size_e   : access size encodings (byte/half/word/dword)
//   state_e  : stage FSM states
//   fwd_w    : forwarding bus width {we, waddr, wdata}
//   misaligned : alignment check of an access against its size
package mem_stage_hs_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

  function automatic int unsigned fwd_w(input int unsigned rf_aw, input int unsigned data_w);
    return 1 + rf_aw + data_w;
  endfunction

  // A dword access on a 32-bit data path has no legal encoding, so it is
  // rejected like a misaligned access and never reaches memory.
  function automatic logic misaligned(input size_e size, input logic [2:0] alo,
                                      input int unsigned data_w);
    logic m;
    case (size)
      SZ_B:    m = 1'b0;
      SZ_H:    m = alo[0];
      SZ_W:    m = |alo[1:0];
      default: m = (data_w != 64) || (|alo);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_hs_lane_align.sv
// mem_lane_align: combinational lane steering for the MEM stage.
//   size, uns, offset : access size, load zero-extend, byte offset in the word
//   st_data           : right-justified store data
//   ld_data           : raw memory read data
//   be                : byte enables shifted to the addressed lanes
//   st_lane           : store data replicated across all lanes
//   ld_ext            : addressed load lane, sign/zero-extended
module mem_lane_align
  import mem_stage_hs_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NB     = DATA_W / 8,
  parameter int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
  input  size_e              size,
  input  logic               uns,
  input  logic [OFF_W-1:0]   offset,
  input  logic [DATA_W-1:0]  st_data,
  input  logic [DATA_W-1:0]  ld_data,
  output logic [NB-1:0]      be,
  output logic [DATA_W-1:0]  st_lane,
  output logic [DATA_W-1:0]  ld_ext
);

  logic [NB-1:0]     be_base;
  logic [DATA_W-1:0] shifted;
  logic              sign;
  int unsigned       nbytes;
  int unsigned       nbits;

  always_comb begin
    nbytes = 32'd1 << size;
    if (nbytes > NB) nbytes = NB;
    nbits = nbytes * 8;

    be_base = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      be_base[i] = (i < nbytes);
    end
    be = be_base << offset;

    // Replicating the low bytes into every lane puts the data under the
    // enabled byte lanes regardless of offset.
    st_lane = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      case (size)
        SZ_B:    st_lane[i*8 +: 8] = st_data[7:0];
        SZ_H:    st_lane[i*8 +: 8] = st_data[(i % 2)*8 +: 8];
        SZ_W:    st_lane[i*8 +: 8] = st_data[(i % 4)*8 +: 8];
        default: st_lane[i*8 +: 8] = st_data[i*8 +: 8];
      endcase
    end

    shifted = ld_data >> {offset, 3'b000};
    sign    = shifted[nbits-1];
    ld_ext  = '0;
    for (int unsigned j = 0; j < DATA_W; j++) begin
      ld_ext[j] = (j < nbits) ? shifted[j] : (~uns & sign);
    end
  end

endmodule

// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM pipeline stage between EX and WB for variable-latency
// data memory using a req/gnt + rvalid protocol.
//   in_*    : EX op (valid/ready handshake, in_ready=0 stalls upstream)
//   mem_*   : memory request (req/we/addr/be/wdata, gnt) and response (rvalid/rdata)
//   out_*   : single-cycle WB result pulse, misalign flag
//   fwd_bus : {we, waddr, wdata}, we only while a writing result is valid
//   flush   : squashes the held op; rst is asynchronous, active-high
module mem_stage_hs
  import mem_stage_hs_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RF_AW  = 5,
  parameter int unsigned PC_W   = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [PC_W-1:0]                     in_pc,
  input  logic                                in_mem_en,
  input  logic                                in_mem_we,
  input  logic [1:0]                          in_size,
  input  logic                                in_uns,
  input  logic [ADDR_W-1:0]                   in_addr,
  input  logic [DATA_W-1:0]                   in_wdata,
  input  logic                                in_rf_we,
  input  logic [RF_AW-1:0]                    in_rf_waddr,
  input  logic [DATA_W-1:0]                   in_ex_result,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [ADDR_W-1:0]                   mem_addr,
  output logic [DATA_W/8-1:0]                 mem_be,
  output logic [DATA_W-1:0]                   mem_wdata,
  input  logic                                mem_gnt,
  input  logic                                mem_rvalid,
  input  logic [DATA_W-1:0]                   mem_rdata,
  output logic                                out_valid,
  output logic [PC_W-1:0]                     out_pc,
  output logic                                out_rf_we,
  output logic [RF_AW-1:0]                    out_rf_waddr,
  output logic [DATA_W-1:0]                   out_rf_wdata,
  output logic                                out_misalign,
  output logic [fwd_w(RF_AW, DATA_W)-1:0]     fwd_bus
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(NB - 1);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                we_q, we_d;
  size_e               size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rf_we_q, rf_we_d;
  logic [RF_AW-1:0]    rf_waddr_q, rf_waddr_d;
  logic                squash_q, squash_d;

  logic                out_valid_q, out_valid_d;
  logic [PC_W-1:0]     out_pc_q, out_pc_d;
  logic                out_rf_we_q, out_rf_we_d;
  logic [RF_AW-1:0]    out_rf_waddr_q, out_rf_waddr_d;
  logic [DATA_W-1:0]   out_rf_wdata_q, out_rf_wdata_d;
  logic                out_misalign_q, out_misalign_d;

  logic [NB-1:0]       lane_be;
  logic [DATA_W-1:0]   lane_wdata;
  logic [DATA_W-1:0]   lane_ld;

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .size    (size_q),
    .uns     (uns_q),
    .offset  (addr_q[OFF_W-1:0]),
    .st_data (wdata_q),
    .ld_data (mem_rdata),
    .be      (lane_be),
    .st_lane (lane_wdata),
    .ld_ext  (lane_ld)
  );

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    we_d           = we_q;
    size_d         = size_q;
    uns_d          = uns_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rf_we_d        = rf_we_q;
    rf_waddr_d     = rf_waddr_q;
    squash_d       = squash_q;
    out_valid_d    = 1'b0;
    out_rf_we_d    = 1'b0;
    out_misalign_d = 1'b0;
    out_pc_d       = out_pc_q;
    out_rf_waddr_d = out_rf_waddr_q;
    out_rf_wdata_d = out_rf_wdata_q;
    in_ready       = 1'b0;
    mem_req        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          if (!in_mem_en) begin
            out_valid_d    = 1'b1;
            out_pc_d       = in_pc;
            out_rf_we_d    = in_rf_we;
            out_rf_waddr_d = in_rf_waddr;
            out_rf_wdata_d = in_ex_result;
          end else if (misaligned(size_e'(in_size), in_addr[2:0], DATA_W)) begin
            out_valid_d    = 1'b1;
            out_misalign_d = 1'b1;
            out_pc_d       = in_pc;
            out_rf_waddr_d = in_rf_waddr;
            out_rf_wdata_d = '0;
          end else begin
            pc_d       = in_pc;
            we_d       = in_mem_we;
            size_d     = size_e'(in_size);
            uns_d      = in_uns;
            addr_d     = in_addr;
            wdata_d    = in_wdata;
            rf_we_d    = in_rf_we;
            rf_waddr_d = in_rf_waddr;
            squash_d   = 1'b0;
            state_d    = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          // Once granted the access is committed; a flush only suppresses the result.
          squash_d = squash_q | flush;
          if (we_q) begin
            out_valid_d    = ~(squash_q | flush);
            out_pc_d       = pc_q;
            out_rf_waddr_d = rf_waddr_q;
            out_rf_wdata_d = '0;
            state_d        = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (flush) squash_d = 1'b1;
        if (mem_rvalid) begin
          if (!(squash_q || flush)) begin
            out_valid_d    = 1'b1;
            out_pc_d       = pc_q;
            out_rf_we_d    = rf_we_q;
            out_rf_waddr_d = rf_waddr_q;
            out_rf_wdata_d = lane_ld;
          end
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pc_q           <= '0;
      we_q           <= 1'b0;
      size_q         <= SZ_B;
      uns_q          <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      squash_q       <= 1'b0;
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_rf_we_q    <= 1'b0;
      out_rf_waddr_q <= '0;
      out_rf_wdata_q <= '0;
      out_misalign_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      we_q           <= we_d;
      size_q         <= size_d;
      uns_q          <= uns_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      squash_q       <= squash_d;
      out_valid_q    <= out_valid_d;
      out_pc_q       <= out_pc_d;
      out_rf_we_q    <= out_rf_we_d;
      out_rf_waddr_q <= out_rf_waddr_d;
      out_rf_wdata_q <= out_rf_wdata_d;
      out_misalign_q <= out_misalign_d;
    end
  end

  // Request signals are combinational from state so an async reset drops them at once.
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = mem_req ? (addr_q & ALIGN_MASK) : '0;
  assign mem_be    = mem_req ? lane_be : '0;
  assign mem_wdata = mem_req ? lane_wdata : '0;

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_rf_we    = out_rf_we_q;
  assign out_rf_waddr = out_rf_waddr_q;
  assign out_rf_wdata = out_rf_wdata_q;
  assign out_misalign = out_misalign_q;
  assign fwd_bus      = {out_valid_q & out_rf_we_q, out_rf_waddr_q, out_rf_wdata_q};

endmodule

// File: tb/tb_mem_stage_hs.sv
module tb_mem_stage_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 32-bit instance ----------------
  logic        rst, flush, in_valid, in_ready, in_mem_en, in_mem_we, in_uns, in_rf_we;
  logic [31:0] in_pc, in_addr, in_wdata, in_ex_result;
  logic [1:0]  in_size;
  logic [4:0]  in_rf_waddr;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        out_valid, out_rf_we, out_misalign;
  logic [31:0] out_pc, out_rf_wdata;
  logic [4:0]  out_rf_waddr;
  logic [37:0] fwd_bus;

  mem_stage_hs #(.DATA_W(32), .ADDR_W(32), .RF_AW(5), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_mem_en(in_mem_en), .in_mem_we(in_mem_we), .in_size(in_size),
    .in_uns(in_uns), .in_addr(in_addr), .in_wdata(in_wdata), .in_rf_we(in_rf_we),
    .in_rf_waddr(in_rf_waddr), .in_ex_result(in_ex_result), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_rf_we(out_rf_we),
    .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata),
    .out_misalign(out_misalign), .fwd_bus(fwd_bus)
  );

  // ---------------- 64-bit instance ----------------
  logic        w_rst, w_flush, w_in_valid, w_in_ready, w_in_mem_en, w_in_mem_we, w_in_uns, w_in_rf_we;
  logic [31:0] w_in_pc, w_in_addr;
  logic [63:0] w_in_wdata, w_in_ex_result;
  logic [1:0]  w_in_size;
  logic [4:0]  w_in_rf_waddr;
  logic        w_mem_req, w_mem_we, w_mem_gnt, w_mem_rvalid;
  logic [31:0] w_mem_addr;
  logic [63:0] w_mem_wdata, w_mem_rdata;
  logic [7:0]  w_mem_be;
  logic        w_out_valid, w_out_rf_we, w_out_misalign;
  logic [31:0] w_out_pc;
  logic [63:0] w_out_rf_wdata;
  logic [4:0]  w_out_rf_waddr;
  logic [69:0] w_fwd_bus;

  mem_stage_hs #(.DATA_W(64), .ADDR_W(32), .RF_AW(5), .PC_W(32)) dut64 (
    .clk(clk), .rst(w_rst), .flush(w_flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_pc(w_in_pc), .in_mem_en(w_in_mem_en), .in_mem_we(w_in_mem_we), .in_size(w_in_size),
    .in_uns(w_in_uns), .in_addr(w_in_addr), .in_wdata(w_in_wdata), .in_rf_we(w_in_rf_we),
    .in_rf_waddr(w_in_rf_waddr), .in_ex_result(w_in_ex_result), .mem_req(w_mem_req),
    .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_be(w_mem_be), .mem_wdata(w_mem_wdata),
    .mem_gnt(w_mem_gnt), .mem_rvalid(w_mem_rvalid), .mem_rdata(w_mem_rdata),
    .out_valid(w_out_valid), .out_pc(w_out_pc), .out_rf_we(w_out_rf_we),
    .out_rf_waddr(w_out_rf_waddr), .out_rf_wdata(w_out_rf_wdata),
    .out_misalign(w_out_misalign), .fwd_bus(w_fwd_bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard (32-bit instance) ----------------
  typedef struct {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        mis;
  } exp_t;

  exp_t sbq[$];

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", {32'd0, out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk("out_pc", {32'd0, out_pc}, {32'd0, e.pc});
          chk("out_rf_we", {63'd0, out_rf_we}, {63'd0, e.rf_we});
          chk("out_waddr", {59'd0, out_rf_waddr}, {59'd0, e.waddr});
          chk("out_misalign", {63'd0, out_misalign}, {63'd0, e.mis});
          if (e.rf_we) begin
            chk("out_wdata", {32'd0, out_rf_wdata}, {32'd0, e.wdata});
            chk("fwd_bus", {26'd0, fwd_bus}, {26'd0, 1'b1, e.waddr, e.wdata});
          end else begin
            chk("fwd_we_nowrite", {63'd0, fwd_bus[37]}, 64'd0);
          end
        end
      end else begin
        chk("fwd_we_idle", {63'd0, fwd_bus[37]}, 64'd0);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        mem_en;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rf_we;
    logic [31:0] ex;
    logic [31:0] rdata;
    int          gd;
    int          rd;
    logic [31:0] exp_wd;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwd;
    logic        mis;
  } vec_t;

  task automatic do_op(input vec_t v, input int idx);
    exp_t e;
    in_valid     = 1'b1;
    in_pc        = 32'h1000 + 32'(idx * 4);
    in_mem_en    = v.mem_en;
    in_mem_we    = v.we;
    in_size      = v.size;
    in_uns       = v.uns;
    in_addr      = v.addr;
    in_wdata     = v.wdata;
    in_rf_we     = v.rf_we;
    in_rf_waddr  = 5'(idx + 1);
    in_ex_result = v.ex;
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    e.pc    = in_pc;
    e.rf_we = v.mem_en ? ((v.mis || v.we) ? 1'b0 : v.rf_we) : v.rf_we;
    e.waddr = in_rf_waddr;
    e.wdata = v.exp_wd;
    e.mis   = v.mis;
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (v.mem_en && !v.mis) begin
      for (int i = 0; i < v.gd; i++) begin
        chk("req_hold", {63'd0, mem_req}, 64'd1);
        chk("stall", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
      end
      chk("mem_req", {63'd0, mem_req}, 64'd1);
      chk("mem_we", {63'd0, mem_we}, {63'd0, v.we});
      chk("mem_addr", {32'd0, mem_addr}, {32'd0, v.addr & 32'hFFFF_FFFC});
      chk("mem_be", {60'd0, mem_be}, {60'd0, v.exp_be});
      if (v.we) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, v.exp_mwd});
      chk("stall_req", {63'd0, in_ready}, 64'd0);
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      if (!v.we) begin
        for (int i = 0; i < v.rd; i++) begin
          chk("wait_noreq", {63'd0, mem_req}, 64'd0);
          chk("stall_wait", {63'd0, in_ready}, 64'd0);
          @(posedge clk); #1;
        end
        chk("wait_noreq", {63'd0, mem_req}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = v.rdata;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
      end
    end else begin
      chk("no_req", {63'd0, mem_req}, 64'd0);
    end
  endtask

  task automatic w_drive(input logic [1:0] size, input logic uns, input logic [31:0] addr);
    w_in_valid  = 1'b1;
    w_in_mem_en = 1'b1;
    w_in_mem_we = 1'b0;
    w_in_size   = size;
    w_in_uns    = uns;
    w_in_addr   = addr;
    w_in_pc     = addr + 32'h4000;
    @(posedge clk); #1;
    w_in_valid  = 1'b0;
  endtask

  vec_t vecs[14];

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    //             mem we sz  uns addr          wdata         rfwe ex            rdata         gd rd exp_wd        be       mwd           mis
    vecs[0]  = '{1'b0, 0, 2'd0, 0, 32'h0,      32'h0,        1, 32'h1234,     32'h0,        0, 0, 32'h1234,     4'b0000, 32'h0,        0};
    vecs[1]  = '{1'b0, 0, 2'd0, 0, 32'h0,      32'h0,        0, 32'hCAFE,     32'h0,        0, 0, 32'hCAFE,     4'b0000, 32'h0,        0};
    vecs[2]  = '{1'b0, 0, 2'd0, 0, 32'h0,      32'h0,        1, 32'hFFFF0001, 32'h0,        0, 0, 32'hFFFF0001, 4'b0000, 32'h0,        0};
    vecs[3]  = '{1'b1, 0, 2'd0, 0, 32'h2003,   32'h0,        1, 32'h0,        32'h80FF0000, 2, 1, 32'hFFFFFF80, 4'b1000, 32'h0,        0};
    vecs[4]  = '{1'b1, 0, 2'd0, 1, 32'h2003,   32'h0,        1, 32'h0,        32'h80FF0000, 2, 1, 32'h00000080, 4'b1000, 32'h0,        0};
    vecs[5]  = '{1'b1, 1, 2'd1, 0, 32'h3002,   32'h0000ABCD, 1, 32'h0,        32'h0,        1, 0, 32'h0,        4'b1100, 32'hABCDABCD, 0};
    vecs[6]  = '{1'b1, 0, 2'd2, 0, 32'h4001,   32'h0,        1, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        1};
    vecs[7]  = '{1'b1, 0, 2'd1, 0, 32'h5002,   32'h0,        1, 32'h0,        32'h80011234, 0, 0, 32'hFFFF8001, 4'b1100, 32'h0,        0};
    vecs[8]  = '{1'b1, 0, 2'd1, 1, 32'h5002,   32'h0,        1, 32'h0,        32'h80011234, 0, 0, 32'h00008001, 4'b1100, 32'h0,        0};
    vecs[9]  = '{1'b1, 0, 2'd2, 0, 32'h6004,   32'h0,        1, 32'h0,        32'hDEADBEEF, 1, 2, 32'hDEADBEEF, 4'b1111, 32'h0,        0};
    vecs[10] = '{1'b1, 1, 2'd0, 0, 32'h7001,   32'h1234565A, 0, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0010, 32'h5A5A5A5A, 0};
    vecs[11] = '{1'b1, 1, 2'd2, 0, 32'h8008,   32'h12345678, 1, 32'h0,        32'h0,        3, 0, 32'h0,        4'b1111, 32'h12345678, 0};
    vecs[12] = '{1'b1, 0, 2'd1, 0, 32'h9003,   32'h0,        1, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        1};
    vecs[13] = '{1'b1, 0, 2'd0, 0, 32'hA000,   32'h0,        1, 32'h0,        32'h1234567F, 0, 0, 32'h0000007F, 4'b0001, 32'h0,        0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_mem_en = 1'b0; in_mem_we = 1'b0;
    in_size = '0; in_uns = 1'b0; in_addr = '0; in_wdata = '0; in_rf_we = 1'b0; in_rf_waddr = '0;
    in_ex_result = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    w_rst = 1'b1; w_flush = 1'b0; w_in_valid = 1'b0; w_in_pc = '0; w_in_mem_en = 1'b0;
    w_in_mem_we = 1'b0; w_in_size = '0; w_in_uns = 1'b0; w_in_addr = '0; w_in_wdata = '0;
    w_in_rf_we = 1'b1; w_in_rf_waddr = 5'd7; w_in_ex_result = '0; w_mem_gnt = 1'b0;
    w_mem_rvalid = 1'b0; w_mem_rdata = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_fwd", {26'd0, fwd_bus}, 64'd0);
    chk("rst_wdata", {32'd0, out_rf_wdata}, 64'd0);
    chk("rst64_in_ready", {63'd0, w_in_ready}, 64'd1);
    chk("rst64_mem_req", {63'd0, w_mem_req}, 64'd0);
    rst = 1'b0;
    w_rst = 1'b0;

    foreach (vecs[i]) do_op(vecs[i], i);

    // Flush while capturing in IDLE: op is dropped.
    in_valid = 1'b1; in_mem_en = 1'b0; in_rf_we = 1'b1; in_ex_result = 32'h5555; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_ov", {63'd0, out_valid}, 64'd0);
    chk("flush_idle_rdy", {63'd0, in_ready}, 64'd1);

    // Flush in REQ before grant: request withdrawn, no result.
    in_valid = 1'b1; in_mem_en = 1'b1; in_mem_we = 1'b0; in_size = 2'd2; in_addr = 32'hB000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("flush_req_pre", {63'd0, mem_req}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_req_drop", {63'd0, mem_req}, 64'd0);
    chk("flush_req_rdy", {63'd0, in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1;

    // Flush in WAIT: still waits for rvalid, completes silently.
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_wait_stall", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    chk("flush_wait_stall2", {63'd0, in_ready}, 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("flush_wait_ov", {63'd0, out_valid}, 64'd0);
    chk("flush_wait_rdy", {63'd0, in_ready}, 64'd1);

    // Flush on the grant cycle of a store: access done, result suppressed.
    in_valid = 1'b1; in_mem_we = 1'b1; in_addr = 32'hC000; in_wdata = 32'h77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mem_gnt = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; flush = 1'b0;
    chk("flush_gnt_ov", {63'd0, out_valid}, 64'd0);
    chk("flush_gnt_rdy", {63'd0, in_ready}, 64'd1);

    // Stage still works after the flush sequences.
    do_op(vecs[0], 20);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    // ---------------- 64-bit data path ----------------
    w_drive(2'd3, 1'b0, 32'h100);
    chk("ld_req", {63'd0, w_mem_req}, 64'd1);
    chk("ld_be", {56'd0, w_mem_be}, 64'hFF);
    chk("ld_addr", {32'd0, w_mem_addr}, 64'h100);
    w_mem_gnt = 1'b1;
    @(posedge clk); #1;
    w_mem_gnt = 1'b0; w_mem_rvalid = 1'b1; w_mem_rdata = 64'h8000_0000_0000_0001;
    @(posedge clk); #1;
    w_mem_rvalid = 1'b0;
    chk("ld_ov", {63'd0, w_out_valid}, 64'd1);
    chk("ld_data", w_out_rf_wdata, 64'h8000_0000_0000_0001);
    chk("ld_fwd_we", {63'd0, w_fwd_bus[69]}, 64'd1);

    w_drive(2'd2, 1'b0, 32'h104);
    chk("lw64_be", {56'd0, w_mem_be}, 64'hF0);
    w_mem_gnt = 1'b1;
    @(posedge clk); #1;
    w_mem_gnt = 1'b0; w_mem_rvalid = 1'b1; w_mem_rdata = 64'h8000_0000_1111_1111;
    @(posedge clk); #1;
    w_mem_rvalid = 1'b0;
    chk("lw64_data", w_out_rf_wdata, 64'hFFFF_FFFF_8000_0000);

    w_drive(2'd1, 1'b1, 32'h106);
    chk("lhu64_be", {56'd0, w_mem_be}, 64'hC0);
    w_mem_gnt = 1'b1;
    @(posedge clk); #1;
    w_mem_gnt = 1'b0; w_mem_rvalid = 1'b1;
    @(posedge clk); #1;
    w_mem_rvalid = 1'b0;
    chk("lhu64_data", w_out_rf_wdata, 64'h0000_0000_0000_8000);

    // Async reset in WAIT: back to IDLE at once, late rvalid ignored.
    w_drive(2'd3, 1'b0, 32'h108);
    w_mem_gnt = 1'b1;
    @(posedge clk); #1;
    w_mem_gnt = 1'b0;
    chk("rstw_stall", {63'd0, w_in_ready}, 64'd0);
    #2 w_rst = 1'b1;
    #1 chk("rstw_rdy", {63'd0, w_in_ready}, 64'd1);
    #2 w_rst = 1'b0;
    @(posedge clk); #1;
    w_mem_rvalid = 1'b1; w_mem_rdata = 64'h1234;
    @(posedge clk); #1;
    w_mem_rvalid = 1'b0;
    chk("rstw_ov", {63'd0, w_out_valid}, 64'd0);
    chk("rstw_rdy2", {63'd0, w_in_ready}, 64'd1);

    // Async reset in REQ: mem_req falls before the next clock edge.
    w_drive(2'd3, 1'b0, 32'h110);
    chk("rstr_req", {63'd0, w_mem_req}, 64'd1);
    #2 w_rst = 1'b1;
    #1 chk("rstr_drop", {63'd0, w_mem_req}, 64'd0);
    #1 w_rst = 1'b0;
    @(posedge clk); #1;
    chk("rstr_idle", {63'd0, w_mem_req}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
